// File: rtl/microtile_alu_acc.sv
// microtile_alu_acc: two-operand ALU with a persistent accumulator.
// Supports add, subtract, accumulate and clear. The accumulator can wrap or
// saturate. Results leave through one registered valid/ready stage, and the
// block counts every accepted transaction.
module microtile_alu_acc #(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int SAT   = 0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             neg,
    output logic             ovf,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] res_nxt;
    logic             neg_nxt;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;
    logic             accept;

    // A new transaction fits when the output register is empty or drains this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign a_ext = ACC_W'(a);
    assign b_ext = ACC_W'(b);

    // The accumulate sum keeps one extra bit, so a carry out of ACC_W bits is
    // visible as overflow.
    assign acc_sum = {1'b0, acc} + (ACC_W+1)'(a) + (ACC_W+1)'(b);

    // Operation decode: the result and the next accumulator/ovf state for the
    // transaction on the inputs.
    always_comb begin
        // NOTE: every output of this block gets a value before the case, so no
        // path through it can leave a signal unassigned and infer a latch.
        res_nxt = '0;
        neg_nxt = 1'b0;
        acc_nxt = acc;
        ovf_nxt = ovf;
        case (mode_e'(mode))
            MODE_ADD: res_nxt = a_ext + b_ext;
            MODE_SUB: begin
                res_nxt = a_ext - b_ext;
                neg_nxt = (a < b);
            end
            MODE_ACC: begin
                if (acc_sum[ACC_W]) begin
                    ovf_nxt = 1'b1;
                    acc_nxt = (SAT != 0) ? '1 : acc_sum[ACC_W-1:0];
                end else begin
                    acc_nxt = acc_sum[ACC_W-1:0];
                end
                res_nxt = acc_nxt;
            end
            MODE_CLR: begin
                acc_nxt = '0;
                ovf_nxt = 1'b0;
            end
        endcase
    end

    // State and output register. Reset takes priority over any handshake.
    // Accept loads a new result. A consume with no accept only drops out_valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge.
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            txn_cnt   <= '0;
        end else if (accept) begin
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            result    <= res_nxt;
            neg       <= neg_nxt;
            out_valid <= 1'b1;
            txn_cnt   <= txn_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/microtile_alu_acc.md
Name: microtile_alu_acc

Overview:
Parametrised successor to the single-adder microtile. It takes two W-bit operands per transaction and performs one of four operations: add, subtract, accumulate or clear. It keeps a persistent ACC_W-bit accumulator with an optional saturating mode, and returns results through a single registered valid/ready output stage. It sits between the tile input pins and the output pins, and also counts accepted transactions.

Parameters:
W, 4, operand width in bits (W >= 2)
ACC_W, 8, accumulator/result width in bits (ACC_W >= W+1)
SAT, 0, 1 = accumulate saturates at all-ones; 0 = accumulate wraps modulo 2^ACC_W
CNT_W, 4, width of the accepted-transaction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operand/mode presented
in_ready  out  1  block can accept this cycle
a  in  W  operand A, unsigned
b  in  W  operand B, unsigned
mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
out_valid  out  1  result register holds unconsumed data
out_ready  in  1  downstream consumes result
result  out  ACC_W  registered result
neg  out  1  SUB result was negative (a < b); 0 for other modes
ovf  out  1  sticky accumulate-overflow flag
txn_cnt  out  CNT_W  number of accepted transactions, modulo 2^CNT_W

Behaviour:
- Reset: rst_n sampled low at a rising edge clears everything. result=0, neg=0, ovf=0, out_valid=0, txn_cnt=0, accumulator=0. Reset overrides any simultaneous handshake. A transaction in flight is discarded.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: one cycle. An accept at edge N gives out_valid=1 and a valid result after edge N.
- Output stage:
  - Holds result, neg and out_valid stable while out_valid=1 and out_ready=0.
  - out_valid && out_ready without an accept clears out_valid. Result data may hold its old value.
  - Consume and accept in the same cycle loads the new result and keeps out_valid=1. Full throughput is 1 per cycle.
- ADD: result = zero_ext(a) + zero_ext(b) in ACC_W bits (never overflows, since ACC_W >= W+1). neg=0. Accumulator unchanged.
- SUB: result = (zero_ext(a) - zero_ext(b)) mod 2^ACC_W. neg = (a < b). Accumulator unchanged.
- ACC:
  - sum = acc + a + b, computed at ACC_W+1 bits.
  - If sum >= 2^ACC_W: ovf<=1. New acc = all-ones if SAT=1, else sum mod 2^ACC_W.
  - Otherwise new acc = sum.
  - result = new acc. neg=0.
- CLR: accumulator<=0, ovf<=0, result=0, neg=0. a and b are ignored.
- ovf is sticky. It clears only on CLR or reset. It is unaffected by ADD/SUB and by the output-stage state.
- Accumulator and ovf update only on accept. A stalled input (in_valid=1, in_ready=0) changes nothing.
- txn_cnt increments by 1 on every accept, all modes included. It wraps from 2^CNT_W-1 to 0.
- mode, a and b are sampled only on accept. Values while not accepted are don't-care.

Test Plan:
- Reset, then ADD a=9 b=7 with out_ready=1 -> one cycle later out_valid=1, result=0x10, neg=0, txn_cnt=1.
- SUB a=3 b=5 -> result=0xFE, neg=1. Then SUB a=5 b=3 -> result=0x02, neg=0. Accumulator still 0.
- SAT=1: CLR, then nine ACC a=15 b=15 back-to-back with out_ready=1 -> results 30,60,...,240, then 255 with ovf=1. One more ACC -> 255, ovf=1. CLR -> result 0, ovf=0.
- SAT=0: same stimulus -> ninth result 0x0E (270 mod 256), ovf=1. ADD 1+1 afterwards -> result 2, ovf stays 1.
- Backpressure: ADD 1+2 accepted, out_ready=0 for 3 cycles with in_valid=1 ACC 4+4 -> result holds 3, in_ready=0, accumulator and txn_cnt unchanged. Raise out_ready -> same-cycle consume and accept, next result 8.
- Reset mid-stream: after ACC total 40 with out_valid=1, pull rst_n low for one edge -> out_valid=0, result=0, ovf=0, txn_cnt=0. Next ACC 1+1 -> result 2. Also 16 accepts with CNT_W=4 -> txn_cnt wraps to 0.
